// File: rtl/axis_sum_pkg.sv
// -----------------------------------------------------------------------------
// axis_sum_pkg
// Shared definitions for the AXI-Stream sum scheduler:
//   - FSM state encoding (IDLE / ALIGN / RUN / ERROR)
//   - err_code values
//   - stream count and the stream-index mapping of the four complex channels
//     (channel 00/01/20/21, real on even bit, imag on odd bit)
// -----------------------------------------------------------------------------
package axis_sum_pkg;

    localparam int NUM_STREAMS  = 8;
    localparam int NUM_CHANNELS = 4;

    // Scheduler states
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ALIGN = 2'd1;
    localparam state_t ST_RUN   = 2'd2;
    localparam state_t ST_ERROR = 2'd3;

    // err_code values
    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_TLAST   = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    // Stream-index mapping: bit 2k = channel k real, bit 2k+1 = channel k imag
    localparam int unsigned IDX_CH00_RE = 0;
    localparam int unsigned IDX_CH00_IM = 1;
    localparam int unsigned IDX_CH01_RE = 2;
    localparam int unsigned IDX_CH01_IM = 3;
    localparam int unsigned IDX_CH20_RE = 4;
    localparam int unsigned IDX_CH20_IM = 5;
    localparam int unsigned IDX_CH21_RE = 6;
    localparam int unsigned IDX_CH21_IM = 7;

    localparam int unsigned CH_RE_IDX [NUM_CHANNELS] =
        '{IDX_CH00_RE, IDX_CH01_RE, IDX_CH20_RE, IDX_CH21_RE};
    localparam int unsigned CH_IM_IDX [NUM_CHANNELS] =
        '{IDX_CH00_IM, IDX_CH01_IM, IDX_CH20_IM, IDX_CH21_IM};

endpackage

// File: rtl/axis_sum_watchdog.sv
// -----------------------------------------------------------------------------
// axis_sum_watchdog
// Stall watchdog for the sum scheduler. Counts consecutive cycles in RUN where
// some, but not all, streams are valid. expire is asserted combinationally on
// the TIMEOUT-th such cycle so the scheduler leaves RUN on that same edge.
// Only instantiated when AXIS_SUM_SCHED_TIMEOUT_EN is defined.
//
// Ports:
//   clock   in   clock
//   resetn  in   asynchronous active-low reset
//   run     in   scheduler is in RUN
//   partial in   |s_tvalid && !&s_tvalid
//   expire  out  stall limit reached this cycle
// -----------------------------------------------------------------------------
module axis_sum_watchdog
    import axis_sum_pkg::*;
#(
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 16
) (
    input  logic clock,
    input  logic resetn,
    input  logic run,
    input  logic partial,
    output logic expire
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] stall_cnt_reg;
    logic             stalling;

    assign stalling = run & partial;
    assign expire   = stalling && (stall_cnt_reg == LIMIT);

    // Restarts whenever the stall streak is broken or has just fired
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            stall_cnt_reg <= '0;
        end else if (!stalling || expire) begin
            stall_cnt_reg <= '0;
        end else begin
            stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
        end
    end

endmodule

// File: rtl/axis_sum_sched.sv
// -----------------------------------------------------------------------------
// axis_sum_sched
// Frame-aligned join scheduler for eight AXI-Stream sources (four complex
// channels) feeding an adder. ALIGN drains each stream up to its next tlast so
// all streams start on a frame boundary; RUN then joins the streams beat by
// beat with a purely combinational handshake, so no stream is consumed alone.
// tlast misalignment during RUN is flagged as a sticky error.
//
// Optional feature: define AXIS_SUM_SCHED_TIMEOUT_EN to add a stall watchdog
// (partial valid for TIMEOUT cycles -> ERROR, err_code=2).
//
// Ports:
//   clock      in   clock (rising edge)
//   resetn     in   asynchronous active-low reset
//   enable     in   request frame-aligned summing (level)
//   clear_err  in   leave ERROR (pulse)
//   s_tvalid   in   [8] stream valids
//   s_tlast    in   [8] stream tlasts
//   s_tready   out  [8] stream readies
//   m_tvalid   out  joined beat valid
//   m_tready   in   adder ready
//   m_tlast    out  last beat of joined frame
//   busy       out  not IDLE
//   err        out  sticky error flag
//   err_code   out  0 none, 1 tlast misalignment, 2 timeout
//   frame_cnt  out  completed joined frames (wraps)
// -----------------------------------------------------------------------------
module axis_sum_sched
    import axis_sum_pkg::*;
#(
    parameter int FRAME_LEN = 256,
    parameter int TIMEOUT   = 1024,
    parameter int CNT_W     = 16
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   enable,
    input  logic                   clear_err,
    input  logic [NUM_STREAMS-1:0] s_tvalid,
    input  logic [NUM_STREAMS-1:0] s_tlast,
    output logic [NUM_STREAMS-1:0] s_tready,
    output logic                   m_tvalid,
    input  logic                   m_tready,
    output logic                   m_tlast,
    output logic                   busy,
    output logic                   err,
    output logic [1:0]             err_code,
    output logic [CNT_W-1:0]       frame_cnt
);

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(FRAME_LEN - 1);

    state_t                 state_reg,     state_next;
    logic [NUM_STREAMS-1:0] done_reg,      done_next;
    logic [CNT_W-1:0]       beat_cnt_reg,  beat_cnt_next;
    logic [CNT_W-1:0]       frame_cnt_reg, frame_cnt_next;
    logic [1:0]             err_code_reg,  err_code_next;
    logic                   err_reg,       err_next;
    logic                   stop_reg,      stop_next;

    logic [NUM_CHANNELS-1:0] ch_valid;
    logic [NUM_STREAMS-1:0]  align_done;
    logic                    in_run;
    logic                    all_valid;
    logic                    fire;
    logic                    last_beat;
    logic                    tlast_mismatch;
    logic                    stall_expire;

    // A channel is joinable when both its real and imag streams are valid
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
            localparam logic [2:0] RE = 3'(CH_RE_IDX[gi]);
            localparam logic [2:0] IM = 3'(CH_IM_IDX[gi]);
            assign ch_valid[gi] = s_tvalid[RE] & s_tvalid[IM];
        end
    endgenerate

    assign in_run         = (state_reg == ST_RUN);
    assign all_valid      = &ch_valid;
    assign m_tvalid       = in_run & all_valid;
    assign fire           = m_tvalid & m_tready;
    assign last_beat      = (beat_cnt_reg == LAST_BEAT);
    assign m_tlast        = m_tvalid & last_beat;
    assign tlast_mismatch = |(s_tlast ^ {NUM_STREAMS{m_tlast}});
    // Streams already aligned stop being drained; ones seeing tlast now finish
    assign align_done     = done_reg | (s_tvalid & ~done_reg & s_tlast);

    assign busy      = (state_reg != ST_IDLE);
    assign err       = err_reg;
    assign err_code  = err_code_reg;
    assign frame_cnt = frame_cnt_reg;

`ifdef AXIS_SUM_SCHED_TIMEOUT_EN
    logic partial_valid;
    assign partial_valid = (|s_tvalid) & ~all_valid;

    axis_sum_watchdog #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_watchdog (
        .clock   (clock),
        .resetn  (resetn),
        .run     (in_run),
        .partial (partial_valid),
        .expire  (stall_expire)
    );
`else
    assign stall_expire = 1'b0;
`endif

    always_comb begin
        s_tready = '0;
        case (state_reg)
            ST_ALIGN: s_tready = ~done_reg;
            ST_RUN:   s_tready = {NUM_STREAMS{fire}};
            default:  s_tready = '0;
        endcase
    end

    always_comb begin
        state_next     = state_reg;
        done_next      = done_reg;
        beat_cnt_next  = beat_cnt_reg;
        frame_cnt_next = frame_cnt_reg;
        err_code_next  = err_code_reg;
        err_next       = err_reg;
        stop_next      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                done_next = '0;
                if (enable) state_next = ST_ALIGN;
            end
            ST_ALIGN: begin
                if (!enable) begin
                    state_next = ST_IDLE;
                    done_next  = '0;
                end else if (&align_done) begin
                    state_next    = ST_RUN;
                    done_next     = '0;
                    beat_cnt_next = '0;
                end else begin
                    done_next = align_done;
                end
            end
            ST_RUN: begin
                // A drop of enable is remembered until the frame ends
                stop_next = stop_reg | ~enable;
                if (fire) begin
                    if (last_beat) begin
                        beat_cnt_next  = '0;
                        frame_cnt_next = frame_cnt_reg + CNT_W'(1);
                    end else begin
                        beat_cnt_next = beat_cnt_reg + CNT_W'(1);
                    end
                end
                // Error detection outranks both the frame-end exit and any
                // clear_err arriving in the same cycle
                if (fire && tlast_mismatch) begin
                    state_next    = ST_ERROR;
                    err_next      = 1'b1;
                    err_code_next = ERR_TLAST;
                end else if (stall_expire) begin
                    state_next    = ST_ERROR;
                    err_next      = 1'b1;
                    err_code_next = ERR_TIMEOUT;
                end else if (fire && last_beat && stop_next) begin
                    state_next = ST_IDLE;
                end
            end
            ST_ERROR: begin
                if (clear_err) begin
                    state_next    = ST_IDLE;
                    err_next      = 1'b0;
                    err_code_next = ERR_NONE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_reg     <= ST_IDLE;
            done_reg      <= '0;
            beat_cnt_reg  <= '0;
            frame_cnt_reg <= '0;
            err_code_reg  <= ERR_NONE;
            err_reg       <= 1'b0;
            stop_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            done_reg      <= done_next;
            beat_cnt_reg  <= beat_cnt_next;
            frame_cnt_reg <= frame_cnt_next;
            err_code_reg  <= err_code_next;
            err_reg       <= err_next;
            stop_reg      <= stop_next;
        end
    end

endmodule

// File: tb/tb_axis_sum_sched.sv
// -----------------------------------------------------------------------------
// tb_axis_sum_sched
// Self-checking bench for axis_sum_sched (FRAME_LEN=4, TIMEOUT=8). A
// behavioural model of the scheduler's rules is advanced on every falling edge
// and compared with all DUT outputs; directed phases add literal expectations
// for alignment, joining, misalignment, timeout and mid-frame reset, followed
// by a randomized phase. Works with or without AXIS_SUM_SCHED_TIMEOUT_EN.
// -----------------------------------------------------------------------------
module tb_axis_sum_sched;

    localparam int FL = 4;
    localparam int TO = 8;
    localparam int CW = 16;
`ifdef AXIS_SUM_SCHED_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clock     = 1'b0;
    logic          resetn    = 1'b0;
    logic          enable    = 1'b0;
    logic          clear_err = 1'b0;
    logic [7:0]    s_tvalid  = 8'h00;
    logic [7:0]    s_tlast   = 8'h00;
    logic          m_tready  = 1'b0;
    logic [7:0]    s_tready;
    logic          m_tvalid;
    logic          m_tlast;
    logic          busy;
    logic          err;
    logic [1:0]    err_code;
    logic [CW-1:0] frame_cnt;

    axis_sum_sched #(.FRAME_LEN(FL), .TIMEOUT(TO), .CNT_W(CW)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .enable    (enable),
        .clear_err (clear_err),
        .s_tvalid  (s_tvalid),
        .s_tlast   (s_tlast),
        .s_tready  (s_tready),
        .m_tvalid  (m_tvalid),
        .m_tready  (m_tready),
        .m_tlast   (m_tlast),
        .busy      (busy),
        .err       (err),
        .err_code  (err_code),
        .frame_cnt (frame_cnt)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // md: 0 idle, 1 aligning, 2 running, 3 error
    int          md      = 0;
    logic [7:0]  mdone   = 8'h00;
    int          mbeat   = 0;
    logic [15:0] mframes = 16'd0;
    int          mstall  = 0;
    bit          mstop   = 1'b0;
    logic [1:0]  mec     = 2'd0;

    // observed joined beats (stimulus bookkeeping and literal checks)
    int          obs_fires = 0;
    logic [31:0] obs_last_mask = 32'h0;

    always @(negedge clock) begin : compare
        logic [7:0] etr, acc, nd;
        logic       emv, elast, efire, partial, stopn;
        if (!resetn) begin
            md = 0; mdone = 8'h00; mbeat = 0; mframes = 16'd0;
            mstall = 0; mstop = 1'b0; mec = 2'd0;
            chk("rst_s_tready", 32'(s_tready), 32'h0);
            chk("rst_m_tvalid", 32'(m_tvalid), 32'h0);
            chk("rst_m_tlast",  32'(m_tlast),  32'h0);
            chk("rst_busy",     32'(busy),     32'h0);
            chk("rst_err",      32'(err),      32'h0);
            chk("rst_err_code", 32'(err_code), 32'h0);
            chk("rst_frame_cnt", 32'(frame_cnt), 32'h0);
        end else begin
            etr = 8'h00; emv = 1'b0; elast = 1'b0;
            if (md == 1) etr = ~mdone;
            if (md == 2) begin
                emv   = (s_tvalid == 8'hFF);
                elast = emv && (mbeat == FL - 1);
                etr   = (emv && m_tready) ? 8'hFF : 8'h00;
            end
            efire = emv && m_tready;
            chk("s_tready",  32'(s_tready),  32'(etr));
            chk("m_tvalid",  32'(m_tvalid),  32'(emv));
            chk("m_tlast",   32'(m_tlast),   32'(elast));
            chk("busy",      32'(busy),      32'(md != 0));
            chk("err",       32'(err),       32'(md == 3));
            chk("err_code",  32'(err_code),  32'(mec));
            chk("frame_cnt", 32'(frame_cnt), 32'(mframes));
            if (md == 2 && !m_tready)
                chk("ready_while_stalled", 32'(s_tready), 32'h0);

            if (s_tready == 8'hFF && m_tvalid) begin
                if (m_tlast && obs_fires < 32) obs_last_mask[obs_fires] = 1'b1;
                obs_fires++;
                $display("beat %0d: pos=%0d last=%0b tlast=%02h frames=%0d",
                         obs_fires, mbeat, m_tlast, s_tlast, frame_cnt);
            end

            case (md)
                0: if (enable) begin md = 1; mdone = 8'h00; end
                1: begin
                    acc = s_tvalid & ~mdone & s_tlast;
                    nd  = mdone | acc;
                    if (!enable) begin
                        md = 0; mdone = 8'h00;
                    end else if (nd == 8'hFF) begin
                        md = 2; mdone = 8'h00; mbeat = 0; mstall = 0; mstop = 1'b0;
                    end else begin
                        mdone = nd;
                    end
                end
                2: begin
                    partial = (s_tvalid != 8'h00) && (s_tvalid != 8'hFF);
                    stopn   = mstop || !enable;
                    if (efire && (s_tlast != {8{elast}})) begin
                        md = 3; mec = 2'd1;
                    end else if (TO_EN && partial && (mstall + 1 >= TO)) begin
                        md = 3; mec = 2'd2;
                    end else if (efire && elast && stopn) begin
                        md = 0;
                    end
                    mstop  = stopn;
                    mstall = partial ? mstall + 1 : 0;
                    if (efire) begin
                        if (mbeat == FL - 1) begin
                            mbeat = 0; mframes = mframes + 16'd1;
                        end else begin
                            mbeat = mbeat + 1;
                        end
                    end
                end
                default: if (clear_err) begin md = 0; mec = 2'd0; end
            endcase
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input logic [7:0] v, input logic [7:0] tl, input logic mr);
        s_tvalid = v;
        s_tlast  = tl;
        m_tready = mr;
        @(posedge clock);
        #1;
    endtask

    // tlast pattern of a well-formed joined frame at the current position
    function automatic logic [7:0] runtl();
        return (mbeat == FL - 1) ? 8'hFF : 8'h00;
    endfunction

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int k;
        int f0;
        logic [7:0] v, tl;
        bit en_state;

        repeat (3) cyc(8'h00, 8'h00, 1'b0);
        resetn = 1'b1;
        cyc(8'h00, 8'h00, 1'b0);
        chk("idle_busy", 32'(busy), 32'h0);

        // ---- alignment: streams 0-3 end on beat 1, streams 4-7 on beat 3
        enable = 1'b1;
        cyc(8'h00, 8'h00, 1'b0);
        chk("align_ready", 32'(s_tready), 32'hFF);
        k = 0;
        while (!m_tvalid && k < 20) begin
            cyc(8'hFF, {(k == 2) ? 4'hF : 4'h0, (k == 0) ? 4'hF : 4'h0}, 1'b0);
            k++;
        end
        chk("align_cycles", 32'(k), 32'd3);
        chk("align_frame_cnt", 32'(frame_cnt), 32'd0);

        // ---- join: 3 frames, m_tready toggling
        obs_fires = 0; obs_last_mask = 32'h0;
        for (int c = 0; c < 24; c++) cyc(8'hFF, runtl(), (c % 2) == 0);
        chk("join_fires", 32'(obs_fires), 32'd12);
        chk("join_last_pos", obs_last_mask, 32'h888);
        chk("join_frame_cnt", 32'(frame_cnt), 32'd3);
        chk("model_frames", 32'(mframes), 32'd3);

        // ---- misalignment: stream 5 tlast on the 3rd beat
        cyc(8'hFF, runtl(), 1'b1);
        cyc(8'hFF, runtl(), 1'b1);
        cyc(8'hFF, 8'h20, 1'b1);
        chk("mis_err", 32'(err), 32'h1);
        chk("mis_code", 32'(err_code), 32'd1);
        chk("mis_ready", 32'(s_tready), 32'h0);
        chk("mis_frame_cnt", 32'(frame_cnt), 32'd3);
        clear_err = 1'b1;
        cyc(8'h00, 8'h00, 1'b0);
        clear_err = 1'b0;
        chk("clr_busy", 32'(busy), 32'h0);
        chk("clr_err", 32'(err), 32'h0);
        chk("clr_code", 32'(err_code), 32'd0);
        chk("clr_frame_cnt", 32'(frame_cnt), 32'd3);

        // ---- partial valid stall
        cyc(8'h00, 8'h00, 1'b0);            // IDLE -> ALIGN
        cyc(8'hFF, 8'hFF, 1'b0);            // all tlast -> RUN
        repeat (7) cyc(8'h7F, 8'h00, 1'b1);
        chk("stall7_err", 32'(err), 32'h0);
        cyc(8'h7F, 8'h00, 1'b1);
`ifdef AXIS_SUM_SCHED_TIMEOUT_EN
        chk("to_err", 32'(err), 32'h1);
        chk("to_code", 32'(err_code), 32'd2);
        clear_err = 1'b1;
        cyc(8'h00, 8'h00, 1'b0);
        clear_err = 1'b0;
        chk("to_clr_code", 32'(err_code), 32'd0);
`else
        chk("noto_busy", 32'(busy), 32'h1);
        chk("noto_code", 32'(err_code), 32'd0);
        f0 = obs_fires;
        cyc(8'hFF, runtl(), 1'b1);
        chk("noto_resume", 32'(obs_fires - f0), 32'd1);
`endif

        // ---- reset in the middle of a frame
        for (k = 0; k < 10 && md != 2; k++) cyc(8'hFF, 8'hFF, 1'b0);
        for (k = 0; k < 10 && mbeat != 2; k++) cyc(8'hFF, runtl(), 1'b1);
        chk("pre_rst_beat", 32'(mbeat), 32'd2);
        chk("pre_rst_busy", 32'(busy), 32'h1);
        s_tvalid = 8'hFF; s_tlast = 8'h00; m_tready = 1'b1;
        #2 resetn = 1'b0;
        #1;
        chk("midrst_s_tready", 32'(s_tready), 32'h0);
        chk("midrst_m_tvalid", 32'(m_tvalid), 32'h0);
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_frame_cnt", 32'(frame_cnt), 32'h0);
        @(posedge clock);
        #1;
        resetn = 1'b1;
        enable = 1'b1;
        cyc(8'h00, 8'h00, 1'b0);
        chk("post_rst_align", 32'(s_tready), 32'hFF);
        chk("post_rst_busy", 32'(busy), 32'h1);

        // ---- randomized phase
        en_state = 1'b1;
        for (int i = 0; i < 700; i++) begin
            if ($urandom_range(0, 39) == 0) en_state = ~en_state;
            enable = en_state;
            clear_err = (md == 3) ? ($urandom_range(0, 3) == 0)
                                  : ($urandom_range(0, 50) == 0);
            v = ($urandom_range(0, 9) < 7) ? 8'hFF : 8'($urandom);
            if ((i % 100) >= 90) v = 8'h7F;
            if (md == 2) begin
                tl = runtl();
                if ($urandom_range(0, 59) == 0) tl = tl ^ (8'h01 << $urandom_range(0, 7));
            end else begin
                tl = 8'($urandom) & 8'($urandom);
            end
            if (i == 350) resetn = 1'b0;
            if (i == 352) resetn = 1'b1;
            cyc(v, tl, $urandom_range(0, 3) != 0);
        end
        clear_err = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
